// File: rtl/reg_display_driver.sv
// Binary-to-7-segment driver for the register-31 display word.
// A double-dabble loop converts one bit per cycle and restarts whenever the input word changes.
module reg_display_driver #(
    parameter int DIGITS      = 8,
    parameter bit BLANK_ZEROS = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           value,
    output logic [7*DIGITS-1:0]   segments,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state_q;
    logic [31:0]          shift_q, last_q;
    logic [39:0]          bcd_q, bcd_adj;
    logic [4:0]           cnt_q;
    logic                 pending_q;
    logic [7*DIGITS-1:0]  seg_q, seg_d;
    logic                 busy_q, done_q, ovf_q, ovf_d;
    logic [71:0]          dabble_d;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h7F;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 10; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
    end

    // The top BCD bit shifted out is always zero: 2^32-1 has a leading digit of 4.
    assign dabble_d = {bcd_adj, shift_q} << 1;

    generate
        if (DIGITS < 10) begin : g_ovf
            assign ovf_d = |bcd_q[39:4*DIGITS];
        end else begin : g_no_ovf
            assign ovf_d = 1'b0;
        end

        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            logic blank;
            // Blank only if this digit and everything above it, out to digit 9, is zero.
            assign blank = BLANK_ZEROS && (k != 0) && !ovf_d && ~|bcd_q[39:4*k];
            assign seg_d[7*k +: 7] = blank ? 7'h7F : enc(bcd_q[4*k +: 4]);
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            last_q    <= '0;
            pending_q <= 1'b1;
            seg_q     <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pending_q || value != last_q) begin
                        shift_q   <= value;
                        last_q    <= value;
                        bcd_q     <= '0;
                        cnt_q     <= '0;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, shift_q} <= dabble_d;
                    cnt_q            <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= DONE;
                end
                DONE: begin
                    seg_q   <= seg_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign segments = seg_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: doc/reg_display_driver.md
# reg_display_driver

Consumes the 32-bit `toDisplay` word that the register file exports from register 31 and drives the board's static 7-segment displays with its unsigned decimal value. A sequential double-dabble converter turns binary into BCD one bit per cycle. A new conversion starts automatically whenever the input word changes. Sits between the register file and the HEX display pins, on the same clock as the register file.

## Interface
- `DIGITS`, default 8: number of displays driven, legal range 1..10; shows the low `DIGITS` decimal digits.
- `BLANK_ZEROS`, default 1: 1 = blank leading zeros, 0 = show all digits.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `clock`.
- `value`  in  32  unsigned word to display; connects to the register file's `toDisplay`.
- `segments`  out  7*DIGITS  active-low segment bus; digit k occupies bits [7k+6:7k], digit 0 = units; bit0 = a … bit6 = g.
- `busy`  out  1  high while a conversion is in progress (states SHIFT and DONE).
- `done`  out  1  one-cycle pulse on the cycle `segments` takes a new value.
- `overflow`  out  1  high when the displayed value has nonzero decimal digits above digit `DIGITS-1`; updated together with `segments`.

## Operation
- Internal state: 32-bit shift register, 40-bit BCD register (10 digits), 5-bit bit counter, `last_value` (32 bits), `pending` flag.
- FSM states are IDLE, SHIFT and DONE.
  - **IDLE:** if `pending` = 1 or `value` != `last_value`, load the shift register and `last_value` from `value`, clear BCD and the counter, clear `pending`, then go to SHIFT. Otherwise stay in IDLE.
  - **SHIFT:** each cycle, add 3 to every BCD digit >= 5 (all digits in parallel). Then shift {BCD, shift register} left by one bit. Increment the counter. After the 32nd shift (counter = 31), go to DONE.
  - **DONE:** encode BCD into `segments`, set `overflow`, pulse `done`, then go to IDLE.
- Digit encoding (hex values, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, blank=7F.
- Blanking (`BLANK_ZEROS` = 1): digit k is blank when it and every BCD digit above it, across the full 10 digits, are zero. Digit 0 is never blanked. When `overflow` = 1, no displayed digit is blanked.
- `overflow` = OR of BCD digits `DIGITS`..9. It is always 0 when `DIGITS` = 10.
- Changes on `value` during SHIFT or DONE do not disturb the running conversion. The next IDLE cycle compares `value` against the captured word and starts again if they differ. Only the final stable value is guaranteed to be displayed.
- All conversion arithmetic is on 4-bit digits. No digit exceeds 9 after any completed cycle.

## Timing
- Reset values: `segments` all 1s (every digit blank), `busy` 0, `done` 0, `overflow` 0, state IDLE, `last_value` 0, `pending` 1.
- With `pending` = 1, the first cycle after reset deasserts converts `value` unconditionally.
- Latency: edge N is the IDLE edge that captures the change. Edges N+1..N+32 perform the shifts. At edge N+33, `segments` and `overflow` update and `done` goes 1 for exactly one cycle.
- `busy` is 1 from after edge N through the DONE cycle; it returns to 0 after edge N+33.
- A steady-state change-to-display latency is 34 cycles, counted from the edge at which the new `value` is first presented.
- Back-to-back conversions: the earliest next capture is edge N+34.
- Reset asserted mid-conversion (SHIFT or DONE): the next edge forces all reset values. No `done` pulse is emitted and no partial result reaches `segments`.
- Reset has priority over every other event in the same cycle.

## Test plan
- **Reset then zero:** reset for 2 cycles, `value` = 0. Required: `done` pulses on the 34th edge after reset release; digit 0 = 40, digits 7..1 = 7F; `overflow` = 0.
- **Full-width digits:** `value` = 12345678, `DIGITS` = 8. Required: digits 7..0 = 79, 24, 30, 19, 12, 02, 78, 00; `busy` high for exactly 33 cycles.
- **Overflow, all-zero low digits:** `value` = 100000000. Required: `overflow` = 1; all 8 digits = 40, not blanked.
- **Maximum input:** `value` = 32'hFFFFFFFF (4294967295). Required: digits show 94967295; `overflow` = 1. With `DIGITS` = 10, all ten digits are shown and `overflow` = 0.
- **Change mid-conversion:** `value` goes 5 → 42 at 10 cycles into the conversion of 5. Required: the first `done` shows "5"; a second conversion starts on the next IDLE edge; the second `done` shows "42" (digits 1..0 = 19, 24).
- **Reset mid-conversion:** reset asserted 20 cycles into SHIFT. Required: `segments` all 7F, `busy` 0, no `done`; a fresh conversion follows reset release.
